// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select. It latches decoded operands and control,
// forwards results from EX/MEM and MEM/WB, and supports stall (hold) and flush (bubble).
module ex_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic          id_alu_src,
    input  logic          id_reg_write,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic [AW-1:0] id_rd_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_alu_res,
    input  logic          wb_reg_write,
    input  logic [AW-1:0] wb_rd_addr,
    input  logic [DW-1:0] wb_data,
    output logic          ex_valid,
    output logic [3:0]    alu_ct,
    output logic [DW-1:0] alu_src1,
    output logic [DW-1:0] alu_src2,
    output logic [AW-1:0] ex_rd_addr,
    output logic          ex_reg_write
);

    logic          valid_r;
    logic [1:0]    alu_op_r;
    logic [5:0]    funct_r;
    logic          alu_src_r;
    logic          reg_write_r;
    logic [AW-1:0] rs_addr_r;
    logic [AW-1:0] rt_addr_r;
    logic [AW-1:0] rd_addr_r;
    logic [DW-1:0] rs_data_r;
    logic [DW-1:0] rt_data_r;
    logic [DW-1:0] imm_r;

    logic [3:0]    alu_ct_s;
    logic [DW-1:0] rs_fwd_s;
    logic [DW-1:0] rt_fwd_s;

    function automatic logic [3:0] decode_ct(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] ct;
        case (op)
            2'b00:   ct = 4'b0010;
            2'b01:   ct = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100000: ct = 4'b0010;
                    6'b100010: ct = 4'b0110;
                    default:   ct = 4'b0000;
                endcase
            end
            default: ct = 4'b0000;
        endcase
        return ct;
    endfunction

    // MEM wins over WB; register 0 is never forwarded
    function automatic logic [DW-1:0] fwd_sel(
        input logic [AW-1:0] addr,
        input logic [DW-1:0] latched,
        input logic          m_we,
        input logic [AW-1:0] m_addr,
        input logic [DW-1:0] m_data,
        input logic          w_we,
        input logic [AW-1:0] w_addr,
        input logic [DW-1:0] w_data
    );
        logic [DW-1:0] res;
        if (addr == {AW{1'b0}}) begin
            res = latched;
        end else if (m_we && (m_addr == addr)) begin
            res = m_data;
        end else if (w_we && (w_addr == addr)) begin
            res = w_data;
        end else begin
            res = latched;
        end
        return res;
    endfunction

    // ID/EX register: flush > stall > load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r     <= 1'b0;
            alu_op_r    <= 2'b00;
            funct_r     <= 6'b000000;
            alu_src_r   <= 1'b0;
            reg_write_r <= 1'b0;
            rs_addr_r   <= {AW{1'b0}};
            rt_addr_r   <= {AW{1'b0}};
            rd_addr_r   <= {AW{1'b0}};
            rs_data_r   <= {DW{1'b0}};
            rt_data_r   <= {DW{1'b0}};
            imm_r       <= {DW{1'b0}};
        end else if (flush) begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            alu_op_r    <= 2'b00;
        end else if (!stall) begin
            valid_r     <= id_valid;
            alu_op_r    <= id_alu_op;
            funct_r     <= id_funct;
            alu_src_r   <= id_alu_src;
            reg_write_r <= id_reg_write & id_valid;
            rs_addr_r   <= id_rs_addr;
            rt_addr_r   <= id_rt_addr;
            rd_addr_r   <= id_rd_addr;
            rs_data_r   <= id_rs_data;
            rt_data_r   <= id_rt_data;
            imm_r       <= id_imm;
        end
    end

    // ALU control decode and operand forwarding, re-evaluated every cycle even while stalled
    always_comb begin
        alu_ct_s = 4'b0000;
        if (valid_r) begin
            alu_ct_s = decode_ct(alu_op_r, funct_r);
        end else begin
            alu_ct_s = 4'b0000;
        end
        rs_fwd_s = fwd_sel(rs_addr_r, rs_data_r, mem_reg_write, mem_rd_addr, mem_alu_res,
                           wb_reg_write, wb_rd_addr, wb_data);
        rt_fwd_s = fwd_sel(rt_addr_r, rt_data_r, mem_reg_write, mem_rd_addr, mem_alu_res,
                           wb_reg_write, wb_rd_addr, wb_data);
    end

    assign ex_valid     = valid_r;
    assign alu_ct       = alu_ct_s;
    assign alu_src1     = rs_fwd_s;
    assign alu_src2     = alu_src_r ? imm_r : rt_fwd_s;
    assign ex_rd_addr   = rd_addr_r;
    assign ex_reg_write = reg_write_r & valid_r;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: a reference model of the ID/EX register pushes expected
// outputs when stimulus is driven; they are popped and compared one cycle later.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        id_valid = 1'b0, id_alu_src = 1'b0, id_reg_write = 1'b0;
    logic [1:0]  id_alu_op = 2'b00;
    logic [5:0]  id_funct = 6'd0;
    logic [4:0]  id_rs_addr = 5'd0, id_rt_addr = 5'd0, id_rd_addr = 5'd0;
    logic [31:0] id_rs_data = 32'd0, id_rt_data = 32'd0, id_imm = 32'd0;
    logic        mem_reg_write = 1'b0, wb_reg_write = 1'b0;
    logic [4:0]  mem_rd_addr = 5'd0, wb_rd_addr = 5'd0;
    logic [31:0] mem_alu_res = 32'd0, wb_data = 32'd0;
    logic        ex_valid, ex_reg_write;
    logic [3:0]  alu_ct;
    logic [31:0] alu_src1, alu_src2;
    logic [4:0]  ex_rd_addr;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        v;
        logic [3:0]  ct;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rd;
        logic        rw;
        logic        known;
    } exp_t;
    exp_t exp_q[$];

    // reference model of the latched fields
    logic        m_valid, m_alu_src, m_rw, m_known;
    logic [1:0]  m_op;
    logic [5:0]  m_funct;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rsd, m_rtd, m_imm;

    ex_operand_stage #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_alu_res(mem_alu_res),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .alu_ct(alu_ct), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_ct(input logic v, input logic [1:0] op, input logic [5:0] f);
        if (!v) return 4'b0000;
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b10 && f == 6'b100000) return 4'b0010;
        if (op == 2'b10 && f == 6'b100010) return 4'b0110;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] d);
        if (a != 5'd0 && mem_reg_write && mem_rd_addr == a) return mem_alu_res;
        if (a != 5'd0 && wb_reg_write && wb_rd_addr == a) return wb_data;
        return d;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_alu_src = 1'b0; m_rw = 1'b0; m_known = 1'b1;
        m_op = 2'b00; m_funct = 6'd0; m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
        m_rsd = 32'd0; m_rtd = 32'd0; m_imm = 32'd0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.v     = m_valid;
        e.ct    = ref_ct(m_valid, m_op, m_funct);
        e.s1    = ref_fwd(m_rs, m_rsd);
        e.s2    = m_alu_src ? m_imm : ref_fwd(m_rt, m_rtd);
        e.rd    = m_rd;
        e.rw    = m_rw & m_valid;
        e.known = m_known;
        return e;
    endfunction

    task automatic check_outputs(input exp_t e);
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
        chk("alu_ct", {28'd0, alu_ct}, {28'd0, e.ct});
        chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
        if (e.known) begin
            chk("alu_src1", alu_src1, e.s1);
            chk("alu_src2", alu_src2, e.s2);
            chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
        end
    endtask

    // Inputs are set at a negedge; advance the model, push expectation, clock, pop and compare.
    task automatic step();
        exp_t e;
        if (flush) begin
            m_valid = 1'b0; m_rw = 1'b0; m_op = 2'b00; m_known = 1'b0;
        end else if (!stall) begin
            m_valid = id_valid; m_op = id_alu_op; m_funct = id_funct; m_alu_src = id_alu_src;
            m_rw = id_reg_write & id_valid; m_rs = id_rs_addr; m_rt = id_rt_addr; m_rd = id_rd_addr;
            m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm; m_known = 1'b1;
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_outputs(e);
        end
    endtask

    task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] f, input logic src,
                          input logic rw, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm);
        id_valid = v; id_alu_op = op; id_funct = f; id_alu_src = src; id_reg_write = rw;
        id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    endtask

    task automatic set_fw(input logic mw, input logic [4:0] ma, input logic [31:0] md,
                          input logic ww, input logic [4:0] wa, input logic [31:0] wd);
        mem_reg_write = mw; mem_rd_addr = ma; mem_alu_res = md;
        wb_reg_write = ww; wb_rd_addr = wa; wb_data = wd;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs(model_out());
        rst = 1'b1;

        // T1: R-type add, no forwarding
        set_id(1'b1, 2'b10, 6'b100000, 1'b0, 1'b1, 5'd5, 5'd6, 5'd9, 32'd7, 32'd3, 32'd0);
        step();
        chk("t1_src1", alu_src1, 32'd7);
        chk("t1_ct", {28'd0, alu_ct}, 32'h2);
        // T2: immediate operand
        set_id(1'b1, 2'b00, 6'd0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 32'h100, 32'h77, 32'hFFFF_FFFC);
        step();
        chk("t2_src2", alu_src2, 32'hFFFF_FFFC);
        // T3: MEM beats WB, then WB alone while stalled
        set_id(1'b1, 2'b01, 6'd0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd4, 32'h11, 32'h22, 32'd0);
        set_fw(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
        step();
        chk("t3_mem_pri", alu_src1, 32'hAA);
        stall = 1'b1;
        set_fw(1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
        step();
        chk("t3_wb", alu_src1, 32'hBB);
        stall = 1'b0;
        // T4: register 0 never forwarded
        set_id(1'b1, 2'b10, 6'b100010, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0);
        set_fw(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        step();
        chk("t4_r0", alu_src1, 32'd0);
        set_fw(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        // reserved op and invalid instruction
        set_id(1'b1, 2'b11, 6'b100000, 1'b0, 1'b1, 5'd2, 5'd3, 5'd8, 32'd1, 32'd2, 32'd0);
        step();
        set_id(1'b0, 2'b00, 6'd0, 1'b0, 1'b1, 5'd2, 5'd3, 5'd8, 32'd1, 32'd2, 32'd0);
        step();
        // T5: hold for 3 cycles with changing id_*, then stall+flush
        set_id(1'b1, 2'b10, 6'b100000, 1'b0, 1'b1, 5'd10, 5'd11, 5'd12, 32'hA, 32'hB, 32'd0);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 2'b01, 6'd0, 1'b1, 1'b0, 5'(i + 1), 5'd1, 5'd1, 32'(i), 32'd9, 32'd9);
            step();
            chk("t5_hold_src1", alu_src1, 32'hA);
        end
        flush = 1'b1;
        step();
        chk("t5_flush_valid", {31'd0, ex_valid}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            set_id(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 0) ? 6'b100000 : 6'($urandom_range(32, 36)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                   $urandom, $urandom, $urandom);
            set_fw(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            step();
        end
        stall = 1'b0; flush = 1'b0;
        set_fw(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // T6: asynchronous reset between edges
        set_id(1'b1, 2'b00, 6'd0, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 32'd0);
        step();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs(model_out());
        #1 rst = 1'b1;
        set_id(1'b1, 2'b10, 6'b100100, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 32'd0);
        @(negedge clk);
        step();
        chk("t6_and_ct", {28'd0, alu_ct}, 32'd0);
        chk("t6_valid", {31'd0, ex_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
